// File: rtl/ud_counter_prescaled.sv
// Up/down counter stepped by a switch-selected prescaler tick.
// Supports parallel load, enable, wrap/saturate and a terminal-count pulse.
module ud_counter_prescaled #(
  parameter int WIDTH = 8,
  parameter int DIV3  = 500000,
  parameter int DIV2  = 5000000,
  parameter int DIV1  = 50000000,
  parameter int DIV0  = 500000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       sw,
  input  logic             ud,
  input  logic             en,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             tc
);

  localparam int M01  = (DIV0 > DIV1) ? DIV0 : DIV1;
  localparam int M23  = (DIV2 > DIV3) ? DIV2 : DIV3;
  localparam int DMAX = (M01 > M23) ? M01 : M23;
  localparam int PW   = $clog2(DMAX);

  localparam logic [PW-1:0] L0 = PW'(DIV0 - 1);
  localparam logic [PW-1:0] L1 = PW'(DIV1 - 1);
  localparam logic [PW-1:0] L2 = PW'(DIV2 - 1);
  localparam logic [PW-1:0] L3 = PW'(DIV3 - 1);

  logic [WIDTH-1:0] r_count;
  logic [PW-1:0]    r_pcnt;
  logic [1:0]       r_sw_q;
  logic             r_tick;
  logic             r_tc;

  logic [PW-1:0]    w_lim;
  logic             w_sw_chg;
  logic             w_wrap;
  logic             w_at_lim;

  always_comb begin
    w_lim = L3;
    unique case (sw)
      2'd0: w_lim = L0;
      2'd1: w_lim = L1;
      2'd2: w_lim = L2;
      2'd3: w_lim = L3;
    endcase
  end

  assign w_sw_chg = (sw != r_sw_q);
  assign w_wrap   = (r_pcnt == w_lim);
  assign w_at_lim = ud ? (r_count == '1) : (r_count == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
      r_pcnt  <= '0;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
      r_sw_q  <= sw;
    end else begin
      r_sw_q <= sw;
      r_tick <= 1'b0;
      r_tc   <= 1'b0;
      if (load) begin
        r_count <= din;
        r_pcnt  <= '0;
      end else if (w_sw_chg) begin
        r_pcnt <= '0;
      end else if (en) begin
        if (w_wrap) begin
          r_pcnt <= '0;
          r_tick <= 1'b1;
          // Limit step: flag tc; saturate holds, wrap jumps to the far end
          if (w_at_lim) begin
            r_tc <= 1'b1;
            if (!sat) r_count <= ud ? '0 : '1;
          end else begin
            r_count <= ud ? r_count + WIDTH'(1)
                          : r_count - WIDTH'(1);
          end
        end else begin
          r_pcnt <= r_pcnt + PW'(1);
        end
      end
    end
  end

  assign led  = r_count;
  assign tick = r_tick;
  assign tc   = r_tc;

endmodule

// File: tb/tb_ud_counter_prescaled.sv
// Scoreboard bench for ud_counter_prescaled (WIDTH=4, DIVs 10/8/6/4).
// Stimulus queues expected outputs by cycle; a monitor checks them.
module tb_ud_counter_prescaled;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] sw;
  logic       ud, en, sat, load;
  logic [3:0] din;
  logic [3:0] led;
  logic       tick, tc;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int         c;
    logic [3:0] led;
    logic       tick;
    logic       tc;
  } exp_t;

  exp_t q[$];

  ud_counter_prescaled #(
    .WIDTH(4), .DIV3(4), .DIV2(6), .DIV1(8), .DIV0(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw(sw), .ud(ud),
    .en(en), .sat(sat), .load(load), .din(din),
    .led(led), .tick(tick), .tc(tc)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit   hit;
    exp_t e;
    hit = 1'b0;
    while (q.size() > 0 && q[0].c <= cyc) begin
      e = q.pop_front();
      n_tests++;
      if (e.c < cyc) begin
        n_fail++;
        $display("FAIL missed_check cyc=%0d", e.c);
      end else begin
        hit = 1'b1;
        if ({led, tick, tc} !== {e.led, e.tick, e.tc}) begin
          n_fail++;
          $display("FAIL out@%0d got led=%0d tick=%b tc=%b exp led=%0d tick=%b tc=%b",
                   cyc, led, tick, tc, e.led, e.tick, e.tc);
        end
      end
    end
    if (tick === 1'b1 && !hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL stray_tick@%0d got led=%0d tc=%b exp no tick",
               cyc, led, tc);
    end
  end

  task automatic ex(input int c, input int l, input bit t, input bit k);
    exp_t e;
    e.c    = c;
    e.led  = 4'(l);
    e.tick = t;
    e.tc   = k;
    q.push_back(e);
  endtask

  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int t;
    reset_n = 1'b0;
    sw = 2'd3; ud = 1'b1; en = 1'b1;
    sat = 1'b0; load = 1'b0; din = 4'd0;
    repeat (2) @(posedge clk);
    #2;
    // Reset state, then 16 up-steps at DIV3 spacing with wrap
    t = cyc;
    ex(t, 0, 0, 0);
    reset_n = 1'b1;
    ex(t + 3, 0, 0, 0);
    for (int k = 1; k <= 16; k++)
      ex(t + 4 * k, k % 16, 1, k == 16);
    go(t + 64);

    t = cyc;
    ud = 1'b0;
    ex(t + 4, 15, 1, 1);
    go(t + 4);
    ud = 1'b1;
    ex(t + 8, 0, 1, 1);
    go(t + 8);
    ud = 1'b0;
    sat = 1'b1;
    ex(t + 12, 0, 1, 1);
    ex(t + 16, 0, 1, 1);
    go(t + 16);
    sat = 1'b0;
    ud = 1'b1;

    // Rate changes clear the prescaler
    t = cyc;
    go(t + 2);
    sw = 2'd0;
    ex(t + 12, 0, 0, 0);
    ex(t + 13, 1, 1, 0);
    go(t + 13);
    sw = 2'd2;
    ex(t + 20, 2, 1, 0);
    ex(t + 26, 3, 1, 0);
    go(t + 26);
    sw = 2'd1;
    ex(t + 35, 4, 1, 0);
    ex(t + 43, 5, 1, 0);
    go(t + 43);
    sw = 2'd3;
    ex(t + 48, 6, 1, 0);
    go(t + 48);

    t = cyc;
    go(t + 2);
    load = 1'b1;
    din = 4'd9;
    ex(t + 3, 9, 0, 0);
    go(t + 3);
    load = 1'b0;
    ex(t + 7, 10, 1, 0);
    go(t + 7);
    en = 1'b0;
    load = 1'b1;
    ex(t + 8, 9, 0, 0);
    go(t + 8);
    load = 1'b0;
    en = 1'b1;
    ex(t + 12, 10, 1, 0);
    go(t + 12);

    // Freeze with two prescaler counts banked
    t = cyc;
    go(t + 2);
    en = 1'b0;
    ex(t + 5, 10, 0, 0);
    ex(t + 9, 10, 0, 0);
    go(t + 9);
    en = 1'b1;
    ex(t + 11, 11, 1, 0);
    go(t + 11);

    t = cyc;
    load = 1'b1;
    din = 4'd7;
    ex(t + 1, 7, 0, 0);
    go(t + 1);
    load = 1'b0;
    go(t + 4);
    reset_n = 1'b0;
    ex(t + 5, 0, 0, 0);
    go(t + 5);
    reset_n = 1'b1;
    ex(t + 8, 0, 0, 0);
    ex(t + 9, 1, 1, 0);
    go(t + 12);

    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL pending got %0d left exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
